uart_tx_block: RTL
==================

Name: uart_tx_block

Overview:
- Serial UART transmitter; the transmit-side counterpart of the lab's APB-configured UART receiver.
- Accepts parallel bytes over a valid/ready handshake into a one-entry holding buffer.
- Serialises each byte as: start bit (0), data_size data bits LSB first, one stop bit (1).
- Each bit lasts data_period clock cycles.
- Sits behind the APB slave register file, which supplies data_size, data_period and the TX data register.

Parameters:
- PERIOD_WIDTH, 14, width of the data_period input and the internal bit timer.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- data_size  input  4  data bits per frame; 5, 7 or 8 honoured, any other value treated as 8
- data_period  input  PERIOD_WIDTH  clock cycles per bit; 0 treated as 1
- tx_data  input  8  byte to send; for size N only tx_data[N-1:0] is transmitted
- tx_valid  input  1  tx_data is valid this cycle
- tx_ready  output  1  holding buffer empty; transfer occurs when tx_valid && tx_ready at a rising edge
- serial_out  output  1  serial line; idle level 1
- tx_busy  output  1  FSM not in IDLE
- tx_done  output  1  one-cycle pulse after each frame's stop bit completes

Behaviour:
- Reset (rst high at an edge) forces, on the same edge:
  - FSM to IDLE; buffer emptied; counters cleared.
  - serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
- Reset mid-frame aborts the frame: line returns to 1 next cycle and the buffered byte is discarded.
- All outputs are registered. tx_ready is !buf_full.
- Holding buffer:
  - Loaded on a handshake edge.
  - Emptied on the edge where the FSM moves its contents into the shift register.
  - No overwrite is possible: tx_valid with tx_ready=0 is ignored, and the source must hold the byte.
- FSM states:
  - IDLE: serial_out=1. If buf_full, go to START on the next edge. Same edge: load shifter from buffer; latch data_size and data_period into frame registers; empty buffer; load bit timer with period-1.
  - START: serial_out=0 for period cycles, then DATA with bit index 0.
  - DATA: serial_out=shifter[0] for period cycles. Shift right at the end of each bit. After bit N-1, go to STOP.
  - STOP: serial_out=1 for period cycles. At the end of the stop bit: pulse tx_done for the next cycle. If buf_full, go directly to START (same load actions as IDLE, no idle gap); otherwise go to IDLE.
- Latency: handshake at edge E0 → buf_full after E0 → START and serial_out=0 after E1 → tx_ready=1 again after E1.
- Frame length is exactly (N+2)*period cycles. Back-to-back frames are contiguous.
- Bit timer: counts down from period-1 to 0. Bit ends on the cycle the count is 0. Period 1 gives one cycle per bit.
- Configuration is sampled only at frame load; changes to data_size or data_period mid-frame affect the next frame only.
- Simultaneous events:
  - A handshake on the same edge the buffer empties is not possible, because ready was 0.
  - A handshake during the final STOP cycle (buffer empty) fills the buffer. The FSM goes to IDLE and then to START one edge later; this gap is legal.
- tx_busy=1 in START, DATA and STOP.

Decomposition:
- Shared package uart_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, STOP}
  - constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1
  - a function mapping data_size to the effective bit count (5, 7, else 8)
- One sub-module, tx_bit_timer:
  - inputs: clk, rst, load, period
  - output: bit_end, a one-cycle strobe
  - reloads on load and on each bit_end while enabled.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst for 2 cycles, tx_valid=0 for 50 cycles.
  - Required: serial_out=1, tx_ready=1, tx_busy=0, tx_done never pulses.
- 8-bit frame:
  - Stimulus: size 8, period 10, send 8'hA5.
  - Required: after E1 the line carries 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. tx_done pulses once 100 cycles after E1.
- 5-bit frame:
  - Stimulus: size 5, period 4, send 8'hF3.
  - Required: line carries 0,1,1,0,0,1,1 (upper bits ignored). Frame is 28 cycles.
- Back-to-back:
  - Stimulus: size 7, period 3. Send 8'h41, then 8'h7F as soon as tx_ready rises.
  - Required: second start bit immediately follows the first stop bit with no idle cycle. tx_ready stays 0 while the buffer is full. Two tx_done pulses, 27 cycles apart.
- Config change and odd values:
  - Stimulus: change data_period from 5 to 2 mid-frame. Separately, run with data_size=4'd3 and data_period=0.
  - Required: the current frame keeps 5 cycles per bit and the next frame uses 2. data_size=3 sends 8 bits; data_period=0 gives 1 cycle per bit.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3 with a byte buffered.
  - Required: serial_out=1 and tx_ready=1 the next cycle. No tx_done pulse. The buffered byte is never sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    // Only 5, 7 and 8 data bits are supported; anything else falls back to 8.
    function automatic logic [3:0] frame_bits(input logic [3:0] size);
        case (size)
            4'd5:    return 4'd5;
            4'd7:    return 4'd7;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Down-counting bit timer: strobes bit_end on the last cycle of each bit period.
module tx_bit_timer #(
    parameter int PERIOD_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    bit_end
);

    logic [PERIOD_WIDTH-1:0] count;
    logic [PERIOD_WIDTH-1:0] period_reg;

    // The period is captured on load so mid-frame input changes cannot stretch bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            period_reg <= PERIOD_WIDTH'(1);
        end else if (load) begin
            period_reg <= period;
            count      <= period - PERIOD_WIDTH'(1);
        end else if (enable) begin
            if (count == '0) begin
                count <= period_reg - PERIOD_WIDTH'(1);
            end else begin
                count <= count - PERIOD_WIDTH'(1);
            end
        end
    end

    assign bit_end = enable && (count == '0);

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: one-entry holding buffer feeding a start/data/stop serialiser.
module uart_tx_block
    import uart_pkg::*;
#(
    parameter int PERIOD_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              data_size,
    input  logic [PERIOD_WIDTH-1:0] data_period,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    serial_out,
    output logic                    tx_busy,
    output logic                    tx_done
);

    tx_state_t               state;
    logic                    buf_full;
    logic [7:0]              buf_data;
    logic [7:0]              shifter;
    logic [2:0]              bit_idx;
    logic [2:0]              last_idx;
    logic                    load;
    logic                    bit_end;
    logic [PERIOD_WIDTH-1:0] eff_period;

    assign eff_period = (data_period == '0) ? PERIOD_WIDTH'(1) : data_period;

    // A new frame starts from IDLE, or straight out of a finishing stop bit.
    assign load = buf_full && ((state == IDLE) || ((state == STOP) && bit_end));

    assign tx_ready = !buf_full;

    tx_bit_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .enable (state != IDLE),
        .period (eff_period),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= LINE_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            shifter    <= '0;
            bit_idx    <= '0;
            last_idx   <= '0;
        end else begin
            tx_done <= (state == STOP) && bit_end;

            if (load) begin
                buf_full <= 1'b0;
            end else if (tx_valid && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end

            if (load) begin
                state      <= START;
                serial_out <= START_LVL;
                tx_busy    <= 1'b1;
                shifter    <= buf_data;
                bit_idx    <= '0;
                last_idx   <= 3'(frame_bits(data_size) - 4'd1);
            end else begin
                case (state)
                    START: begin
                        if (bit_end) begin
                            state      <= DATA;
                            bit_idx    <= '0;
                            serial_out <= shifter[0];
                        end
                    end
                    // serial_out is driven one bit ahead from shifter[1] so it stays registered.
                    DATA: begin
                        if (bit_end) begin
                            if (bit_idx == last_idx) begin
                                state      <= STOP;
                                serial_out <= STOP_LVL;
                            end else begin
                                bit_idx    <= bit_idx + 3'd1;
                                shifter    <= shifter >> 1;
                                serial_out <= shifter[1];
                            end
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            state      <= IDLE;
                            serial_out <= LINE_IDLE;
                            tx_busy    <= 1'b0;
                        end
                    end
                    default: begin
                        serial_out <= LINE_IDLE;
                        tx_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
